ffo_serializer: RTL
===================

FFO_SERIALIZER -- requirements
Module: ffo_serializer

Interface
REQ-001 SHALL have parameter N, default 32, meaning request vector width; legal values are powers of two from 2 to 64.
REQ-002 SHALL derive localparam PW = $clog2(N), default 5, meaning position field width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_vec is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_vec this cycle.
REQ-007 SHALL have port in_vec, input, [0:N-1]: request vector; bit 0 is the highest-priority (first) position.
REQ-008 SHALL have port out_valid, output, 1 bit: out_pos holds a valid index.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes out_pos this cycle.
REQ-010 SHALL have port out_pos, output, [0:PW-1]: index of the lowest-numbered set bit still pending.
REQ-011 SHALL have port out_last, output, 1 bit: out_pos is the final set bit of the current vector.
REQ-012 SHALL have port out_remaining, output, [0:PW]: count of pending set bits, including the one on out_pos.

Function
REQ-013 SHALL implement two states: IDLE and SCAN.
REQ-014 SHALL drive in_ready = 1 exactly when in IDLE, independent of in_valid.
REQ-015 SHALL, in IDLE with in_valid=1, register in_vec into the pending vector and set out_remaining to its popcount on the same edge.
REQ-016 SHALL move to SCAN on that edge if the accepted vector is nonzero; SHALL discard an all-zero vector, stay IDLE, and produce no output.
REQ-017 SHALL assert out_valid exactly when in SCAN; the first out_valid appears the cycle after acceptance (latency 1).
REQ-018 SHALL drive out_pos combinationally from the registered pending vector as the index of its lowest-numbered 1 (find-first-one, bit 0 first).
REQ-019 SHALL drive out_last = 1 exactly when out_remaining == 1 in SCAN.
REQ-020 SHALL, on out_valid && out_ready, clear the pending bit at out_pos and decrement out_remaining; out_pos then moves to the next set bit in the following cycle.
REQ-021 SHALL, on out_valid && out_ready && out_last, return to IDLE; in_ready rises the following cycle, giving one bubble between vectors.
REQ-022 SHALL hold out_pos, out_last and out_remaining stable while out_valid=1 and out_ready=0 (stall, any length).
REQ-023 SHALL ignore in_valid and in_vec while in SCAN; a new vector cannot overwrite pending bits.
REQ-024 SHALL ignore out_ready while in IDLE.
REQ-025 SHALL, with one vector of k set bits and out_ready held at 1, emit k indices on k consecutive cycles in strictly increasing order.
REQ-026 SHALL drive out_pos = 0 and out_last = 0 whenever out_valid = 0.
REQ-027 SHALL handle N=32 with the all-ones vector: 32 outputs, positions 0..31, out_remaining 32 down to 1.

Reset
REQ-028 SHALL, when reset=1 on a rising edge, force state IDLE, clear the pending vector and set out_remaining=0, regardless of state or handshakes.
REQ-029 SHALL hold these reset output values during and after reset until the next acceptance: in_ready=1, out_valid=0, out_pos=0, out_last=0.
REQ-030 SHALL, when reset is asserted mid-SCAN, drop all pending bits; no further outputs from that vector appear after reset deasserts.

Verification
REQ-031 SHALL be verified with N=32, in_vec=32'h1000_4001 (bits 3,17,31), out_ready=1 -> out_pos 3,17,31 on three consecutive cycles; out_remaining 3,2,1; out_last only with 31; in_ready returns the next cycle.
REQ-032 SHALL be verified with in_vec=0 accepted -> no out_valid ever, and in_ready stays 1.
REQ-033 SHALL be verified with in_vec=32'h8000_0001 and out_ready low for 5 cycles -> out_pos=0 held stable for those 5 cycles, then 0 followed by 31.
REQ-034 SHALL be verified with in_valid held high during SCAN carrying 32'hFFFF_FFFF -> that vector is ignored; only the first vector's bits are emitted, and the new vector is accepted only once back in IDLE.
REQ-035 SHALL be verified with reset asserted after the first output of 32'hF000_0000 -> next cycle out_valid=0, in_ready=1, out_remaining=0.
REQ-036 SHALL be verified with a random-vector sweep where out_pos is checked against a find-first-one reference model on every handshake.

Source files
------------

// File: rtl/ffo_serializer.sv
// ffo_serializer: accepts a request vector and emits its set-bit indices, lowest index first
module ffo_serializer #(
    parameter int N = 32,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:N-1]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:PW-1] out_pos,
    output logic          out_last,
    output logic [0:PW]   out_remaining
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state_q, state_d;
    logic [0:N-1] pend_q;
    logic [PW:0] rem_q, cnt;
    logic [PW-1:0] ffo;
    logic accept, take;
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == SCAN;
    assign accept = in_valid && in_ready;
    assign take = out_valid && out_ready;
    assign out_pos = out_valid ? ffo : '0;
    assign out_last = out_valid && rem_q == (PW+1)'(1);
    assign out_remaining = rem_q;
    // population count of the offered vector, loaded as the pending count on acceptance
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + {{PW{1'b0}}, in_vec[i]};
    end
    // find-first-one over pending bits: descending scan so the lowest index wins
    always_comb begin
        ffo = '0;
        for (int i = N - 1; i >= 0; i--) if (pend_q[i]) ffo = PW'(i);
    end
    // next state: nonzero vectors start a scan; the last handshake returns to idle
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = (in_valid && |in_vec) ? SCAN : IDLE;
        else state_d = (take && out_last) ? IDLE : SCAN;
    end
    // state, pending vector and remaining count; reset drops any in-flight vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q <= '0;
            rem_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pend_q <= in_vec;
                rem_q <= cnt;
            end else if (take) begin
                pend_q[ffo] <= 1'b0;
                rem_q <= rem_q - 1'b1;
            end
        end
    end
endmodule
